// File: rtl/csla_sched_pkg.sv
// Shared definitions for the carry-select adder scheduler.
//   state_e  : scheduler FSM states
//   WORD_W   : width of one adder word
//   rr_pick  : rotated-priority pick. Returns the first set request after
//              'last', wrapping at n, or -1 when nothing is requesting.
package csla_sched_pkg;

  localparam int WORD_W  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
    int pick;
    int idx;
    pick = -1;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (last + k) % n;
      if (k <= n && pick < 0 && req[idx[2:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   last_grant  : index granted last time; search starts just above it
//   grant       : one-hot grant (all zero when no request)
//   grant_idx   : encoded grant index
//   grant_valid : any request granted
module rr_arbiter
  import csla_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_valid
);

  logic [MAX_REQ-1:0] req_ext;
  int                 pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, int'(last_grant), N);
    grant_valid    = (pick >= 0);
    grant_idx      = grant_valid ? ID_W'(pick) : '0;
    for (int i = 0; i < N; i++) grant[i] = (pick == i);
  end

endmodule

// File: rtl/sqrt_csla.sv
// 32-bit square-root carry-select adder.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low 32 bits)
//   cout : carry out of bit 31
// Block widths grow 2,2,3,4,5,6,10 so each block's two precomputed sums are
// ready about when the carry from the previous block selects between them.
module sqrt_csla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int NBLK = 7;

  function automatic int blk_lo(input int g);
    case (g)
      0:       return 0;
      1:       return 2;
      2:       return 4;
      3:       return 7;
      4:       return 11;
      5:       return 16;
      6:       return 22;
      default: return 32;
    endcase
  endfunction

  logic [NBLK:0] c;
  assign c[0] = cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    localparam int LO = blk_lo(g);
    localparam int W  = blk_lo(g + 1) - blk_lo(g);
    logic [W:0] s0;
    logic [W:0] s1;
    assign s0 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]};
    assign s1 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + {{W{1'b0}}, 1'b1};
    assign sum[LO +: W] = c[g] ? s1[W-1:0] : s0[W-1:0];
    assign c[g+1]       = c[g] ? s1[W]     : s0[W];
  end

  assign cout = c[NBLK];

endmodule

// File: rtl/csla_add_scheduler.sv
// Time-shares one 32-bit carry-select adder among N_REQ requesters. Each
// accepted request is a WORDS*32-bit add executed one word per cycle, LSW
// first, with the carry held in a register between words.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (ready one-hot, IDLE only)
//   req_a, req_b, req_cin : packed operands, requester i at [i*OW +: OW]
//   rsp_valid/rsp_ready   : result handshake
//   rsp_id, rsp_sum, rsp_cout : owner, sum and carry out of the result
//   busy                  : FSM not in IDLE
//
// state | meaning
// IDLE  | arbitrate; accept the granted request
// EXEC  | add word widx, carry kept in carry_q
// DONE  | hold result until rsp_ready
module csla_add_scheduler
  import csla_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WORDS = 2,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int OW    = WORD_W * WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*OW-1:0] req_a,
  input  logic [N_REQ*OW-1:0] req_b,
  input  logic [N_REQ-1:0]    req_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [OW-1:0]       rsp_sum,
  output logic                rsp_cout,
  output logic                busy
);

  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e              state_q, state_d;
  logic [OW-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic [ID_W-1:0]     id_q, id_d, last_q, last_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic [WORD_W-1:0]   add_x, add_y, add_sum;
  logic                add_cin, add_cout;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req         (req_valid),
    .last_grant  (last_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign add_x   = a_q[widx_q*WORD_W +: WORD_W];
  assign add_y   = b_q[widx_q*WORD_W +: WORD_W];
  assign add_cin = (widx_q == '0) ? cin_q : carry_q;

  sqrt_csla u_add (
    .a    (add_x),
    .b    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    id_d    = id_q;
    last_d  = last_q;
    widx_d  = widx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          a_d     = req_a[grant_idx*OW +: OW];
          b_d     = req_b[grant_idx*OW +: OW];
          cin_d   = req_cin[grant_idx];
          id_d    = grant_idx;
          last_d  = grant_idx;
          widx_d  = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d[widx_q*WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        widx_d  = widx_q + 1'b1;
        if (widx_q == WIDX_W'(WORDS - 1)) begin
          cout_d  = add_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      widx_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      last_q  <= last_d;
      widx_q  <= widx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Ready is gated by rst as well so nothing looks accepted during reset.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_csla_add_scheduler.sv
module tb_csla_add_scheduler;

  localparam int N_REQ = 4;
  localparam int WORDS = 2;
  localparam int OW    = 32 * WORDS;
  localparam int ID_W  = 2;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*OW-1:0] req_a;
  logic [N_REQ*OW-1:0] req_b;
  logic [N_REQ-1:0]    req_cin;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [OW-1:0]       rsp_sum;
  logic                rsp_cout;
  logic                busy;

  csla_add_scheduler #(.N_REQ(N_REQ), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [OW-1:0]   sum;
    logic            cout;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [OW-1:0] a_v [N_REQ];
  logic [OW-1:0] b_v [N_REQ];
  logic          c_v [N_REQ];

  task automatic chk(input string tag, input logic [OW:0] obs, input logic [OW:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin);
    exp_t        e;
    logic [OW:0] t;
    t      = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
    e.id   = ID_W'(id);
    e.sum  = t[OW-1:0];
    e.cout = t[OW];
    return e;
  endfunction

  task automatic set_req(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin);
    a_v[i] = a;
    b_v[i] = b;
    c_v[i] = cin;
    req_a[i*OW +: OW] = a;
    req_b[i*OW +: OW] = b;
    req_cin[i]        = cin;
  endtask

  // Drive a single request in IDLE, confirm it is the one granted, and
  // return just after the accept edge with valid withdrawn.
  task automatic issue(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin, input string tag);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    set_req(i, a, b, cin);
    req_valid[i] = 1'b1;
    #1;
    chk({tag, "_ready"}, req_ready, oh);
    sb.push_back(model(i, a, b, cin));
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, rsp_id, e.id);
      chk({tag, "_sum"}, rsp_sum, e.sum);
      chk({tag, "_cout"}, rsp_cout, e.cout);
    end
  endtask

  task automatic get_rsp(input string tag, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    check_pop(tag);
    @(negedge clk);
    chk({tag, "_released"}, rsp_valid, 0);
  endtask

  int lat;
  int seen;
  int g, r, guard, last_acc;
  int order [5] = '{0, 1, 2, 3, 0};
  exp_t held;

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_req(i, '0, '0, 1'b0);

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("idle_no_req_ready", req_ready, 0);

    // word carry propagation, latency
    issue(0, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, "t1");
    chk("t1_busy", busy, 1);
    get_rsp("t1", lat);
    chk("t1_latency", lat, 3);

    // all-ones + zero + cin
    issue(2, '1, '0, 1'b1, "t2");
    get_rsp("t2", lat);

    // lone requester granted again
    issue(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, "t3");
    get_rsp("t3", lat);

    // reset while widx = 1
    issue(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, "rstx");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstx_busy", busy, 0);
    chk("rstx_valid", rsp_valid, 0);
    rst = 1'b0;
    sb.delete();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("rstx_no_rsp", seen, 0);

    // all four valid: rotation 0,1,2,3,0 with wrap
    for (int i = 0; i < N_REQ; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    req_valid = '1;
    g = 0; r = 0; guard = 0; last_acc = 0;
    while (r < 5 && guard < 60) begin
      #1;
      if (req_ready != '0 && g < 5) begin
        chk("rr_grant", req_ready, 4'b0001 << order[g]);
        if (g > 0) chk("rr_spacing", cyc - last_acc, WORDS + 2);
        sb.push_back(model(order[g], a_v[order[g]], b_v[order[g]], c_v[order[g]]));
        last_acc = cyc;
        g++;
      end
      if (rsp_valid) begin
        check_pop("rr");
        r++;
      end
      if (r < 5) begin
        @(negedge clk);
        guard++;
        if (g == 5 && req_valid[0]) begin
          req_valid = 4'b1010;
          set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        end
      end
    end
    chk("rr_rsp_count", r, 5);

    // requester 1 withdraws before its turn; requester 3 wins
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_grant", req_ready, 4'b1000);
    sb.push_back(model(3, a_v[3], b_v[3], c_v[3]));
    @(negedge clk);
    req_valid = '0;
    get_rsp("drop", lat);

    // consumer stalls 5 cycles in DONE
    rsp_ready = 1'b0;
    issue(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, "stall");
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("stall_valid", rsp_valid, 1);
    held = sb[0];
    set_req(3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    req_valid[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_hold_valid", rsp_valid, 1);
      chk("stall_hold_id", rsp_id, held.id);
      chk("stall_hold_sum", rsp_sum, held.sum);
      chk("stall_hold_cout", rsp_cout, held.cout);
      chk("stall_no_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check_pop("stall");
    @(negedge clk);
    #1;
    chk("stall_next_grant", req_ready, 4'b1000);
    chk("stall_idle", busy, 0);
    req_valid = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
